// File: rtl/data_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pipe
//  Purpose  : Word-organised data memory with a multi-cycle FSM front end that
//             serves RISC-V byte/half/word loads and stores, incl. split access.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_pipe #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 256,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int c_MW = $clog2(MEM_SIZE);
    // Wide enough that index+1 and MEM_SIZE compare without overflow or truncation.
    localparam int c_CW = ADDR_WIDTH + 17;
    localparam logic [31:0] c_INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC0 = 2'd1;
    localparam logic [1:0] c_ACC1 = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [31:0] r_mem [MEM_SIZE] = '{default: c_INIT_WORD};

    logic            r_we;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [c_MW-1:0] r_widx;
    logic [7:0]      r_be;
    logic [63:0]     r_wd64;
    logic            r_split;
    logic            r_fault;
    logic [31:0]     r_rd_lo;
    logic [31:0]     r_rd_hi;

    // ------------------------------------------------------------------
    // Request decode, evaluated on the live request in the accept cycle
    // ------------------------------------------------------------------
    logic [1:0]            w_off;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic [c_CW-1:0]       w_idx_ext;
    logic                  w_legal;
    logic [3:0]            w_szmask;
    logic [7:0]            w_be;
    logic [63:0]           w_wd64;
    logic                  w_split;
    logic                  w_fault;
    logic                  w_accept;

    assign w_off     = req_addr[1:0];
    assign w_idx     = req_addr[ADDR_WIDTH-1:2];
    assign w_idx_ext = c_CW'(w_idx);
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_legal  = 1'b0;
        w_szmask = 4'b1111;
        if (req_we) begin
            w_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            w_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (req_funct3[1:0])
            2'b00:   w_szmask = 4'b0001;
            2'b01:   w_szmask = 4'b0011;
            default: w_szmask = 4'b1111;
        endcase
    end

    // Bytes that spill past offset 3 land in the upper half: that is the split.
    assign w_be    = 8'({4'b0000, w_szmask} << w_off);
    assign w_wd64  = {32'h0000_0000, req_wdata} << {w_off, 3'b000};
    assign w_split = |w_be[7:4];
    assign w_fault = !w_legal
                  || (w_idx_ext >= c_CW'(MEM_SIZE))
                  || (w_split && ((w_idx_ext + c_CW'(1)) >= c_CW'(MEM_SIZE)));

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_off   <= w_off;
            r_widx  <= w_idx[c_MW-1:0];
            r_be    <= w_be;
            r_wd64  <= w_wd64;
            r_split <= w_split;
            r_fault <= w_fault;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next = c_ACC0;
            c_ACC0:  w_next = (r_split && !r_fault) ? c_ACC1 : c_RESP;
            c_ACC1:  w_next = c_RESP;
            default: w_next = c_IDLE;
        endcase
    end

    logic [31:0] w_merged;
    logic [31:0] w_load;

    always_comb begin
        req_ready  = (r_state == c_IDLE) && !rst;
        resp_valid = (r_state == c_RESP);
        resp_err   = resp_valid && r_fault;
        resp_rdata = (resp_valid && !r_we && !r_fault) ? w_load : 32'h0000_0000;
    end

    // ------------------------------------------------------------------
    // Memory access: one word per ACC cycle, low word then word+1
    // ------------------------------------------------------------------
    logic            w_acc;
    logic            w_hi;
    logic [c_MW-1:0] w_midx;
    logic [3:0]      w_mbe;
    logic [31:0]     w_mwd;

    assign w_acc  = (r_state == c_ACC0) || (r_state == c_ACC1);
    assign w_hi   = (r_state == c_ACC1);
    assign w_midx = w_hi ? (r_widx + c_MW'(1)) : r_widx;
    assign w_mbe  = w_hi ? r_be[7:4] : r_be[3:0];
    assign w_mwd  = w_hi ? r_wd64[63:32] : r_wd64[31:0];

    // Reset only suppresses a pending write; stored contents are never cleared.
    always_ff @(posedge clk) begin
        if (w_acc && !r_fault) begin
            if (r_we) begin
                if (!rst) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_mbe[b]) begin
                            r_mem[w_midx][8*b +: 8] <= w_mwd[8*b +: 8];
                        end
                    end
                end
            end else if (w_hi) begin
                r_rd_hi <= r_mem[w_midx];
            end else begin
                r_rd_lo <= r_mem[w_midx];
            end
        end
    end

    assign w_merged = 32'({r_rd_hi, r_rd_lo} >> {r_off, 3'b000});

    always_comb begin
        case (r_f3)
            3'b000:  w_load = {{24{w_merged[7]}}, w_merged[7:0]};
            3'b001:  w_load = {{16{w_merged[15]}}, w_merged[15:0]};
            3'b100:  w_load = {24'h000000, w_merged[7:0]};
            3'b101:  w_load = {16'h0000, w_merged[15:0]};
            default: w_load = w_merged;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_pipe
//  Purpose  : Directed self-checking bench for data_mem_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_pipe;

    localparam logic [2:0] c_B  = 3'b000;
    localparam logic [2:0] c_H  = 3'b001;
    localparam logic [2:0] c_W  = 3'b010;
    localparam logic [2:0] c_BU = 3'b100;
    localparam logic [2:0] c_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_pipe #(
        .ADDR_WIDTH (32),
        .MEM_SIZE   (256),
        .INIT_ZERO  (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/rdata"}, resp_rdata, exp_rd);
        chk({tag, "/err"}, 32'(resp_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "/pulse"}, {31'd0, resp_valid} | resp_rdata, 32'd0);
    endtask

    logic [2:0]  b_f3   [4] = '{3'b010, 3'b010, 3'b100, 3'b010};
    logic [31:0] b_addr [4] = '{32'h10, 32'h22, 32'h13, 32'h24};
    logic [31:0] b_exp  [4] = '{32'h80AD_BEEF, 32'h1122_3344, 32'h0000_0080, 32'h0000_1122};

    initial begin
        int n_resp;
        int ia;
        int jr;
        int ov;
        int last_c;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst/ready", 32'(req_ready), 32'd0);
        chk("rst/valid", 32'(resp_valid), 32'd0);
        chk("rst/rdata", resp_rdata, 32'd0);
        chk("rst/err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst/ready_release", 32'(req_ready), 32'd1);
        @(negedge clk);

        do_req("sw_10",   1'b1, c_W,  32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        do_req("lw_10",   1'b0, c_W,  32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        do_req("sb_13",   1'b1, c_B,  32'h13, 32'h0000_0080, 2, 32'h0, 1'b0);
        do_req("lb_13",   1'b0, c_B,  32'h13, 32'h0, 2, 32'hFFFF_FF80, 1'b0);
        do_req("lbu_13",  1'b0, c_BU, 32'h13, 32'h0, 2, 32'h0000_0080, 1'b0);
        do_req("lw_10b",  1'b0, c_W,  32'h10, 32'h0, 2, 32'h80AD_BEEF, 1'b0);
        do_req("lb_12",   1'b0, c_B,  32'h12, 32'h0, 2, 32'hFFFF_FFAD, 1'b0);
        do_req("lh_12",   1'b0, c_H,  32'h12, 32'h0, 2, 32'hFFFF_80AD, 1'b0);
        do_req("lhu_12",  1'b0, c_HU, 32'h12, 32'h0, 2, 32'h0000_80AD, 1'b0);

        do_req("sw_22",   1'b1, c_W,  32'h22, 32'h1122_3344, 3, 32'h0, 1'b0);
        do_req("lw_20",   1'b0, c_W,  32'h20, 32'h0, 2, 32'h3344_0000, 1'b0);
        do_req("lw_24",   1'b0, c_W,  32'h24, 32'h0, 2, 32'h0000_1122, 1'b0);
        do_req("lw_22",   1'b0, c_W,  32'h22, 32'h0, 3, 32'h1122_3344, 1'b0);
        do_req("lh_23",   1'b0, c_H,  32'h23, 32'h0, 3, 32'h0000_2233, 1'b0);

        do_req("lh_top",  1'b0, c_H,  32'h3FF, 32'h0, 2, 32'h0, 1'b1);
        do_req("lw_end",  1'b0, c_W,  32'h400, 32'h0, 2, 32'h0, 1'b1);
        do_req("lw_last", 1'b0, c_W,  32'h3FC, 32'h0, 2, 32'h0, 1'b0);
        do_req("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 2, 32'h0, 1'b1);
        do_req("sw_f100", 1'b1, 3'b100, 32'h10, 32'h5555_5555, 2, 32'h0, 1'b1);
        do_req("lw_10c",  1'b0, c_W,  32'h10, 32'h0, 2, 32'h80AD_BEEF, 1'b0);

        // Reset lands in ACC1 of a split halfword store.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = c_H;
        req_addr   = 32'h43;
        req_wdata  = 32'h0000_ABCD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        n_resp = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        rst = 1'b0;
        #1;
        chk("abort/ready_release", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        chk("abort/no_resp", 32'(n_resp), 32'd0);
        do_req("abort_lw40", 1'b0, c_W, 32'h40, 32'h0, 2, 32'hCD00_0000, 1'b0);
        do_req("abort_lw44", 1'b0, c_W, 32'h44, 32'h0, 2, 32'h0000_0000, 1'b0);

        // req_valid held high across a stream of four loads.
        ia     = 0;
        jr     = 0;
        ov     = 0;
        last_c = -1;
        for (int c = 0; c < 30; c++) begin
            if (resp_valid) begin
                if (jr < 4) chk("b2b/rdata", resp_rdata, b_exp[jr]);
                jr++;
                last_c = c;
                if (req_ready) ov++;
            end
            if (ia < 4) begin
                req_valid  = 1'b1;
                req_we     = 1'b0;
                req_funct3 = b_f3[ia];
                req_addr   = b_addr[ia];
                #1;
                if (req_ready) ia++;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b/accepts", 32'(ia), 32'd4);
        chk("b2b/responses", 32'(jr), 32'd4);
        chk("b2b/ready_in_resp", 32'(ov), 32'd0);
        chk("b2b/last_resp_cycle", 32'(last_c), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
